operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the ALU and drives the 8x16 register file read ports.
- Captures the decoded instruction together with both source operands into an ID/EX register.
- Resolves RAW hazards by forwarding from EX and WB, and inserts bubbles on load-use hazards.
- Uses valid/ready handshakes on both sides and supports a pipeline flush for branches.

Parameters:
- DATA_W, 16, operand and data width.
- ADDR_W, 3, register address width (8 registers; r0 reads as zero).
- OP_W, 4, opcode width.
- LOAD_STALL, 1, bubbles inserted on a load-use hazard (1..3).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  OP_W  opcode.
- in_rs1, in_rs2  in  ADDR_W  source registers.
- in_rd  in  ADDR_W  destination register.
- in_regwrite  in  1  instruction writes rd.
- in_memread  in  1  instruction is a load.
- in_imm  in  DATA_W  sign-extended immediate.
- rf_addr1, rf_addr2  out  ADDR_W  register file read addresses (combinational copies of in_rs1/in_rs2).
- rf_data1, rf_data2  in  DATA_W  register file read data (combinational).
- fwd_ex_valid, fwd_ex_rd, fwd_ex_data  in  1/ADDR_W/DATA_W  EX/MEM result bypass (non-load).
- fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/ADDR_W/DATA_W  WB bypass; same cycle as the register file write.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  ALU stage accepts.
- out_op, out_rd, out_regwrite, out_memread, out_imm  out  as inputs  registered copies.
- out_a, out_b  out  DATA_W  registered resolved operands.

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all out_* data fields=0; FSM=RUN; stall counter=0.
- Advance condition: adv = out_ready | ~out_valid.
- Operand resolution, per source, in priority order:
  - rs==0 → 0.
  - fwd_ex_valid & fwd_ex_rd==rs → fwd_ex_data.
  - fwd_wb_valid & fwd_wb_rd==rs → fwd_wb_data.
  - otherwise rf_data.
  - r0 is never forwarded, even if a bypass port carries rd=0.
- Hazard: hz = in_valid & out_valid & out_memread & out_regwrite & out_rd!=0 & (out_rd==in_rs1 | out_rd==in_rs2).
- FSM RUN:
  - in_ready = adv & ~hz.
  - Accept (in_valid & in_ready) → ID/EX loads the instruction and resolved operands next edge; out_valid=1. Latency is 1 cycle.
  - adv & ~in_valid → out_valid=0.
  - adv & hz → out_valid=0 (bubble), counter=LOAD_STALL-1, go to STALL if LOAD_STALL>1, else stay in RUN. The held load has left, so the next cycle re-evaluates with the load's value arriving via a bypass port.
  - ~adv → all outputs hold; in_ready=0.
- FSM STALL:
  - in_ready=0.
  - On each adv: insert a bubble, decrement the counter.
  - Counter reaches 0 → RUN.
- Flush (highest priority, synchronous):
  - Next edge: out_valid=0, FSM=RUN, counter=0.
  - in_ready=0 during the flush cycle; the incoming instruction is dropped.
- Flush coinciding with out_ready: the held instruction counts as consumed downstream; flush still clears the register.
- Reset mid-stall: returns to RUN with out_valid=0 immediately.
- Data fields are don't-care when out_valid=0; the implementation clears out_regwrite and out_memread on bubbles.
- No arithmetic is performed; widths pass through unchanged.

Decomposition:
- Shared package cpu_pkg holds DATA_W, ADDR_W, OP_W, the opcode constants, and the REG_ZERO=3'd0 constant.
- One natural sub-module, operand_bypass_mux: a combinational rs/rf_data/ex/wb → operand selector, instantiated twice.
- The FSM and ID/EX register stay in the top module.

Test Plan:
- Plain pass: rs1=2, rs2=3, rf_data 0x1111/0x2222, no bypass, out_ready=1 → next cycle out_valid=1, out_a=0x1111, out_b=0x2222.
- Forward priority: rs1=4, ex rd=4 data 0xAAAA, wb rd=4 data 0xBBBB, rf 0xCCCC → out_a=0xAAAA. Drop ex_valid → 0xBBBB.
- r0 guard: rs1=0, ex rd=0 data 0xFFFF, rf_data1=0x5555 → out_a=0x0000.
- Load-use: load rd=5 held, next instruction rs2=5 → in_ready=0 for one cycle and one bubble (out_valid=0). Next cycle wb rd=5 data 0x0042 → out_b=0x0042. Repeat with LOAD_STALL=2 → two bubbles.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → the instruction is accepted exactly once.
- Flush/reset: flush asserted with out_valid=1 and in_valid=1 → next cycle out_valid=0 and the input is not accepted. Pulse rst_n=0 mid-STALL → out_valid=0 asynchronously and FSM=RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: widths, opcode encodings, the hard-wired
// zero register, and the operand-fetch stage FSM state type.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned OP_W   = 4;

    // r0 always reads as zero and is never a forwarding target.
    localparam logic [2:0] REG_ZERO = 3'd0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_ADDI = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_BEQ  = 4'hA,
        OP_BNE  = 4'hB,
        OP_JAL  = 4'hC,
        OP_NOP  = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } of_state_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Combinational source-operand selector: r0 guard, then EX bypass, then WB
// bypass, then register file data.
module operand_bypass_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    // Priority select; the r0 test comes first so a bypass carrying rd=0
    // can never override the hard-wired zero.
    always_comb begin
        operand = rf_data;
        if (rs == ADDR_W'(REG_ZERO)) begin
            operand = '0;
        end else if (ex_valid && (ex_rd == rs)) begin
            operand = ex_data;
        end else if (wb_valid && (wb_rd == rs)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: reads/bypasses both source operands, captures the
// instruction into the ID/EX register, and inserts bubbles on load-use hazards.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned OP_W       = cpu_pkg::OP_W,
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              fwd_ex_valid,
    input  logic [ADDR_W-1:0] fwd_ex_rd,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic              fwd_wb_valid,
    input  logic [ADDR_W-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_regwrite,
    output logic              out_memread,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b
);

    // Bubbles beyond the first are counted down in STALL.
    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    of_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              out_regwrite_q, out_regwrite_d;
    logic              out_memread_q, out_memread_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;

    logic              adv;
    logic              hz;
    logic              accept;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign rf_addr1 = in_rs1;
    assign rf_addr2 = in_rs2;

    operand_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux_a (
        .rs       (in_rs1),
        .rf_data  (rf_data1),
        .ex_valid (fwd_ex_valid),
        .ex_rd    (fwd_ex_rd),
        .ex_data  (fwd_ex_data),
        .wb_valid (fwd_wb_valid),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .operand  (opnd_a)
    );

    operand_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux_b (
        .rs       (in_rs2),
        .rf_data  (rf_data2),
        .ex_valid (fwd_ex_valid),
        .ex_rd    (fwd_ex_rd),
        .ex_data  (fwd_ex_data),
        .wb_valid (fwd_wb_valid),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .operand  (opnd_b)
    );

    // Handshake and load-use hazard detection against the held instruction.
    always_comb begin
        adv = out_ready | ~out_valid_q;
        hz  = in_valid & out_valid_q & out_memread_q & out_regwrite_q
            & (out_rd_q != '0)
            & ((out_rd_q == in_rs1) | (out_rd_q == in_rs2));
        in_ready = 1'b0;
        if (!flush && (state_q == ST_RUN)) begin
            in_ready = adv & ~hz;
        end
        accept = in_valid & in_ready;
    end

    // Next-state for the FSM and ID/EX register; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_op_d       = out_op_q;
        out_rd_d       = out_rd_q;
        out_regwrite_d = out_regwrite_q;
        out_memread_d  = out_memread_q;
        out_imm_d      = out_imm_q;
        out_a_d        = out_a_q;
        out_b_d        = out_b_q;

        if (flush) begin
            out_valid_d    = 1'b0;
            out_regwrite_d = 1'b0;
            out_memread_d  = 1'b0;
            state_d        = ST_RUN;
            cnt_d          = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (adv) begin
                        if (accept) begin
                            out_valid_d    = 1'b1;
                            out_op_d       = in_op;
                            out_rd_d       = in_rd;
                            out_regwrite_d = in_regwrite;
                            out_memread_d  = in_memread;
                            out_imm_d      = in_imm;
                            out_a_d        = opnd_a;
                            out_b_d        = opnd_b;
                        end else begin
                            out_valid_d    = 1'b0;
                            out_regwrite_d = 1'b0;
                            out_memread_d  = 1'b0;
                            if (hz) begin
                                cnt_d = STALL_INIT;
                                if (LOAD_STALL > 1) begin
                                    state_d = ST_STALL;
                                end
                            end
                        end
                    end
                end
                ST_STALL: begin
                    if (adv) begin
                        out_valid_d    = 1'b0;
                        out_regwrite_d = 1'b0;
                        out_memread_d  = 1'b0;
                        if (cnt_q <= 2'd1) begin
                            cnt_d   = '0;
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and ID/EX register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_op_q       <= '0;
            out_rd_q       <= '0;
            out_regwrite_q <= 1'b0;
            out_memread_q  <= 1'b0;
            out_imm_q      <= '0;
            out_a_q        <= '0;
            out_b_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_op_q       <= out_op_d;
            out_rd_q       <= out_rd_d;
            out_regwrite_q <= out_regwrite_d;
            out_memread_q  <= out_memread_d;
            out_imm_q      <= out_imm_d;
            out_a_q        <= out_a_d;
            out_b_q        <= out_b_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_op       = out_op_q;
    assign out_rd       = out_rd_q;
    assign out_regwrite = out_regwrite_q;
    assign out_memread  = out_memread_q;
    assign out_imm      = out_imm_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: two instances share all inputs,
// one with a single load-use bubble and one with two.
module tb_operand_fetch_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned OW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [OW-1:0] in_op;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic          in_regwrite, in_memread;
    logic [DW-1:0] in_imm;
    logic [DW-1:0] rf_data1, rf_data2;
    logic          fwd_ex_valid, fwd_wb_valid;
    logic [AW-1:0] fwd_ex_rd, fwd_wb_rd;
    logic [DW-1:0] fwd_ex_data, fwd_wb_data;
    logic          flush;
    logic          out_ready;

    logic          in_ready1, in_ready2;
    logic [AW-1:0] rf_addr1_1, rf_addr2_1, rf_addr1_2, rf_addr2_2;
    logic          out_valid1, out_valid2;
    logic [OW-1:0] out_op1, out_op2;
    logic [AW-1:0] out_rd1, out_rd2;
    logic          out_regwrite1, out_regwrite2;
    logic          out_memread1, out_memread2;
    logic [DW-1:0] out_imm1, out_imm2;
    logic [DW-1:0] out_a1, out_a2, out_b1, out_b2;

    int n_checks = 0;
    int n_errors = 0;
    int acc1 = 0;
    int acc_snap;

    always #5 clk = ~clk;

    operand_fetch_stage #(.LOAD_STALL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_imm(in_imm),
        .rf_addr1(rf_addr1_1), .rf_addr2(rf_addr2_1),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .out_op(out_op1), .out_rd(out_rd1), .out_regwrite(out_regwrite1),
        .out_memread(out_memread1), .out_imm(out_imm1), .out_a(out_a1), .out_b(out_b1)
    );

    operand_fetch_stage #(.LOAD_STALL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_imm(in_imm),
        .rf_addr1(rf_addr1_2), .rf_addr2(rf_addr2_2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_op(out_op2), .out_rd(out_rd2), .out_regwrite(out_regwrite2),
        .out_memread(out_memread2), .out_imm(out_imm2), .out_a(out_a2), .out_b(out_b2)
    );

    // Count accepted handshakes on the single-bubble instance.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready1) acc1 <= acc1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [OW-1:0] op, input logic [AW-1:0] rs1,
                             input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                             input logic rw, input logic mr, input logic [DW-1:0] imm);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_regwrite = rw;
        in_memread  = mr;
        in_imm      = imm;
    endtask

    task automatic clear_fwd();
        fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
        fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_regwrite = 1'b0; in_memread = 1'b0; in_imm = '0;
        rf_data1 = '0; rf_data2 = '0;
        clear_fwd();

        // Reset state
        #12;
        check("rst_valid1", out_valid1, 0);
        check("rst_valid2", out_valid2, 0);
        check("rst_a1", out_a1, 0);
        check("rst_op1", out_op1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain pass
        set_instr(4'h3, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 16'h0007);
        rf_data1 = 16'h1111; rf_data2 = 16'h2222;
        #1;
        check("rf_addr1", rf_addr1_1, 2);
        check("rf_addr2", rf_addr2_1, 3);
        check("plain_ready", in_ready1, 1);
        tick();
        check("plain_valid", out_valid1, 1);
        check("plain_a", out_a1, 16'h1111);
        check("plain_b", out_b1, 16'h2222);
        check("plain_op", out_op1, 4'h3);
        check("plain_rd", out_rd1, 1);
        check("plain_imm", out_imm1, 16'h0007);
        check("plain_rw", out_regwrite1, 1);
        check("plain_a2", out_a2, 16'h1111);

        // Forward priority: EX over WB over RF
        set_instr(4'h0, 3'd4, 3'd0, 3'd1, 1'b1, 1'b0, 16'h0000);
        fwd_ex_valid = 1'b1; fwd_ex_rd = 3'd4; fwd_ex_data = 16'hAAAA;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 3'd4; fwd_wb_data = 16'hBBBB;
        rf_data1 = 16'hCCCC; rf_data2 = 16'h9999;
        tick();
        check("fwd_ex", out_a1, 16'hAAAA);
        check("rs2_zero", out_b1, 0);
        fwd_ex_valid = 1'b0;
        tick();
        check("fwd_wb", out_a1, 16'hBBBB);
        fwd_wb_valid = 1'b0;
        tick();
        check("fwd_rf", out_a1, 16'hCCCC);

        // r0 is never forwarded
        in_rs1 = 3'd0; in_rs2 = 3'd0;
        fwd_ex_valid = 1'b1; fwd_ex_rd = 3'd0; fwd_ex_data = 16'hFFFF;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 3'd0; fwd_wb_data = 16'hEEEE;
        rf_data1 = 16'h5555;
        tick();
        check("r0_ex", out_a1, 0);
        check("r0_wb", out_b1, 0);
        in_rs2 = 3'd6; fwd_wb_rd = 3'd6; fwd_wb_data = 16'h0606;
        tick();
        check("fwd_wb_b", out_b1, 16'h0606);
        check("r0_a_again", out_a1, 0);
        clear_fwd();
        in_valid = 1'b0;
        tick();
        check("idle_valid1", out_valid1, 0);
        check("idle_valid2", out_valid2, 0);

        // Load-use hazard
        set_instr(4'h8, 3'd1, 3'd0, 3'd5, 1'b1, 1'b1, 16'h0004);
        rf_data1 = 16'h0100;
        tick();
        check("ld_valid1", out_valid1, 1);
        check("ld_memread1", out_memread1, 1);
        check("ld_valid2", out_valid2, 1);
        set_instr(4'h0, 3'd0, 3'd5, 3'd6, 1'b1, 1'b0, 16'h0000);
        rf_data2 = 16'hDEAD;
        #1;
        check("hz_ready1", in_ready1, 0);
        check("hz_ready2", in_ready2, 0);
        tick();
        check("bubble_valid1", out_valid1, 0);
        check("bubble_valid2", out_valid2, 0);
        check("bubble_memread1", out_memread1, 0);
        fwd_wb_valid = 1'b1; fwd_wb_rd = 3'd5; fwd_wb_data = 16'h0042;
        #1;
        check("post_ready1", in_ready1, 1);
        check("stall_ready2", in_ready2, 0);
        tick();
        check("lu_valid1", out_valid1, 1);
        check("lu_b1", out_b1, 16'h0042);
        check("bubble2_valid2", out_valid2, 0);
        #1;
        check("post_ready2", in_ready2, 1);
        tick();
        check("lu_valid2", out_valid2, 1);
        check("lu_b2", out_b2, 16'h0042);
        in_valid = 1'b0;
        clear_fwd();
        tick();

        // Backpressure
        set_instr(4'h5, 3'd2, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0000);
        rf_data1 = 16'h1234;
        tick();
        check("bp_first_a", out_a1, 16'h1234);
        out_ready = 1'b0;
        set_instr(4'h6, 3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 16'h0000);
        rf_data1 = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", in_ready1, 0);
            tick();
            check("bp_hold_a", out_a1, 16'h1234);
            check("bp_hold_op", out_op1, 4'h5);
            check("bp_hold_valid", out_valid1, 1);
        end
        acc_snap = acc1;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready1, 1);
        tick();
        check("bp_new_a", out_a1, 16'h5678);
        check("bp_new_op", out_op1, 4'h6);
        in_valid = 1'b0;
        tick();
        check("bp_drained", out_valid1, 0);
        check("bp_accept_once", acc1 - acc_snap, 1);

        // Flush
        set_instr(4'h7, 3'd2, 3'd0, 3'd2, 1'b1, 1'b0, 16'h0001);
        rf_data1 = 16'h0001;
        tick();
        check("fl_pre_valid", out_valid1, 1);
        flush = 1'b1; out_ready = 1'b0;
        set_instr(4'h9, 3'd2, 3'd0, 3'd4, 1'b1, 1'b0, 16'h0000);
        #1;
        check("fl_ready1", in_ready1, 0);
        check("fl_ready2", in_ready2, 0);
        tick();
        check("fl_valid1", out_valid1, 0);
        check("fl_rw1", out_regwrite1, 0);
        check("fl_valid2", out_valid2, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("fl_dropped", out_valid1, 0);

        // Reset in the middle of a stall
        set_instr(4'h8, 3'd1, 3'd0, 3'd5, 1'b1, 1'b1, 16'h0000);
        tick();
        set_instr(4'h0, 3'd5, 3'd0, 3'd6, 1'b1, 1'b0, 16'h0000);
        tick();
        #1;
        check("ms_stall_ready2", in_ready2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ms_rst_valid2", out_valid2, 0);
        check("ms_rst_run2", in_ready2, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous clear of a held instruction
        set_instr(4'h2, 3'd2, 3'd0, 3'd1, 1'b1, 1'b0, 16'h0000);
        rf_data1 = 16'hBEEF;
        tick();
        check("ar_pre_a", out_a1, 16'hBEEF);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid1, 0);
        check("ar_a", out_a1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
